router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
//  Packet source for the router 1x3 input port. Buffers one packet's payload from an upstream
//  byte stream, then drives the router's pkt_valid/data_in interface in order: header
//  {len[5:0],addr[1:0]}, then len payload bytes, then the parity byte. Honours the router's busy
//  back-pressure. Serves as the host-side transmitter and as a reusable stimulus source for
//  router-level benches.
// PARAMETERS
//  GAP_CYCLES  1  idle cycles (pkt_valid=0) after the parity byte before tx_ready re-asserts; >=1
//  ERR_INJ_EN  1  1: err_inj honoured; 0: err_inj ignored, parity always correct
// PORTS
//  clock      in   1  single clock, all logic on posedge
//  reset      in   1  synchronous, active-high reset
//  start      in   1  packet request; sampled only while tx_ready=1
//  addr       in   2  destination port 0..2; sampled with start
//  len        in   6  payload length 0..63; sampled with start
//  err_inj    in   1  sampled with start; 1 = send bitwise-inverted parity
//  tx_ready   out  1  1 in IDLE only
//  pl_data    in   8  payload byte from upstream
//  pl_valid   in   1  pl_data valid
//  pl_ready   out  1  block accepts pl_data this cycle
//  busy       in   1  router busy; 1 = current word not consumed this edge
//  pkt_valid  out  1  router pkt_valid
//  data_out   out  8  router data_in
//  pkt_done   out  1  one-cycle pulse, first GAP cycle
//  addr_err   out  1  one-cycle pulse, start rejected because addr==2'b11
// BEHAVIOUR
//  Reset: state=IDLE, pkt_valid=0, data_out=8'h00, pl_ready=0, pkt_done=0, addr_err=0, tx_ready=1;
//   buffer contents, index and parity accumulator discarded. Reset in any state, incl. mid-packet,
//   aborts the packet; no parity byte is sent.
//  pkt_valid, data_out, pl_ready, pkt_done, addr_err come straight from flops (no comb. paths).
//  Payload buffer: 64 x 8. Parity accumulator P: 8 bits, initialised to header at start.
//  FSM states IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP:
//   IDLE: start & addr!=3 -> latch addr/len/err_inj, P<=header; go to LOAD if len>0, else HEADER.
//         start & addr==3 -> addr_err=1 next cycle, stay IDLE. start outside IDLE is ignored.
//   LOAD: pl_ready=1 while stored count<len. On each pl_valid&pl_ready: buf[count]<=pl_data,
//         P<=P^pl_data. The edge storing byte len-1 -> HEADER. pl_valid gaps only stall LOAD.
//   HEADER: pkt_valid=1, data_out={len,addr}. Edge with busy=0 -> PAYLOAD with idx=0,
//         or PARITY if len==0.
//   PAYLOAD: pkt_valid=1, data_out=buf[idx]. Edge with busy=0 -> idx+1; after idx==len-1 -> PARITY.
//         No bubbles: consecutive busy=0 edges send one byte per cycle.
//   PARITY: pkt_valid=0, data_out = P, or ~P when err_inj & ERR_INJ_EN.
//         Edge with busy=0 -> GAP.
//   GAP: pkt_valid=0, data_out=0, pkt_done=1 in the first cycle only.
//         After GAP_CYCLES cycles -> IDLE.
//  busy=1 on an edge holds state, idx, data_out and pkt_valid unchanged. busy is ignored in
//   IDLE/LOAD/GAP.
//  Every word in HEADER..PARITY is presented for >=1 cycle. The router consumes it on the first
//   edge with busy=0. No word is ever dropped or duplicated.
//  Latency, busy=0 throughout: start edge to header on data_out = len+1 cycles (len>0) or
//   1 cycle (len=0). Header to parity = len+1 cycles.
// TESTING
//  1 reset held 2 cycles mid-PAYLOAD -> next cycle pkt_valid=0, data_out=00, tx_ready=1;
//    new packet then sends correctly.
//  2 start addr=2 len=8, 8 random bytes, busy=0 -> 8'h22, 8 bytes back-to-back with pkt_valid=1,
//    then parity = XOR of all 9 bytes with pkt_valid=0; pkt_done pulses once.
//  3 as 2 with busy=1 for 2 cycles on the header and 1 cycle on payload byte 3 -> each held word is
//    stable; router-side capture matches the sent sequence with no loss or duplication.
//  4 len=0 addr=1 -> header 8'h01, then parity 8'h01. len=63 addr=2 -> header 8'hFE,
//    63 bytes, correct parity.
//  5 err_inj=1, len=4 -> parity byte = ~(correct parity). With ERR_INJ_EN=0 -> correct parity.
//  6 start addr=3 -> addr_err pulse, pkt_valid stays 0. Start pulsed during PAYLOAD -> ignored.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Host-side packet transmitter for the 1x3 router input port: buffers one payload from an
// upstream byte stream, then sends header, payload and parity while honouring router busy.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 1,
    parameter bit ERR_INJ_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] len,
    input  logic       err_inj,
    output logic       tx_ready,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       addr_err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t          state;
    logic [7:0]      pkt_buf [64];
    logic [1:0]      addr_q;
    logic [5:0]      len_q;
    logic            err_q;
    logic [5:0]      count;
    logic [5:0]      idx;
    logic [7:0]      par;
    logic [GW-1:0]   gap_cnt;

    logic [7:0]      hdr_in;
    logic [7:0]      hdr_q;
    logic            load_fire;
    logic            load_last;
    logic [7:0]      par_out;

    assign hdr_in    = {len, addr};
    assign hdr_q     = {len_q, addr_q};
    assign load_fire = (state == LOAD) && pl_valid && pl_ready;
    assign load_last = load_fire && (count == len_q - 6'd1);
    assign par_out   = (err_q && ERR_INJ_EN) ? ~par : par;
    assign tx_ready  = (state == IDLE);

    // Payload store has no reset so it can map onto plain RAM; stale bytes are never sent.
    always_ff @(posedge clock) begin
        if (load_fire) begin
            pkt_buf[count] <= pl_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            pl_ready  <= 1'b0;
            pkt_done  <= 1'b0;
            addr_err  <= 1'b0;
            addr_q    <= 2'd0;
            len_q     <= 6'd0;
            err_q     <= 1'b0;
            count     <= 6'd0;
            idx       <= 6'd0;
            par       <= 8'h00;
            gap_cnt   <= '0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (addr == 2'b11) begin
                            addr_err <= 1'b1;
                        end else begin
                            addr_q <= addr;
                            len_q  <= len;
                            err_q  <= err_inj;
                            par    <= hdr_in;
                            count  <= 6'd0;
                            if (len != 6'd0) begin
                                state    <= LOAD;
                                pl_ready <= 1'b1;
                            end else begin
                                state     <= HEADER;
                                pkt_valid <= 1'b1;
                                data_out  <= hdr_in;
                            end
                        end
                    end
                end

                LOAD: begin
                    if (load_fire) begin
                        count <= count + 6'd1;
                        par   <= par ^ pl_data;
                        if (load_last) begin
                            pl_ready  <= 1'b0;
                            state     <= HEADER;
                            pkt_valid <= 1'b1;
                            data_out  <= hdr_q;
                        end
                    end
                end

                HEADER: begin
                    if (!busy) begin
                        idx <= 6'd0;
                        if (len_q == 6'd0) begin
                            state     <= PARITY;
                            pkt_valid <= 1'b0;
                            data_out  <= par_out;
                        end else begin
                            state    <= PAYLOAD;
                            data_out <= pkt_buf[0];
                        end
                    end
                end

                // Next byte is prefetched on the consuming edge so busy=0 streams without bubbles.
                PAYLOAD: begin
                    if (!busy) begin
                        if (idx == len_q - 6'd1) begin
                            state     <= PARITY;
                            pkt_valid <= 1'b0;
                            data_out  <= par_out;
                        end else begin
                            idx      <= idx + 6'd1;
                            data_out <= pkt_buf[idx + 6'd1];
                        end
                    end
                end

                PARITY: begin
                    if (!busy) begin
                        state    <= GAP;
                        data_out <= 8'h00;
                        pkt_done <= 1'b1;
                        gap_cnt  <= '0;
                    end
                end

                GAP: begin
                    pkt_done <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    pkt_valid <= 1'b0;
                    data_out  <= 8'h00;
                    pl_ready  <= 1'b0;
                    pkt_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed scoreboard bench for router_pkt_tx: expected words are queued as packets are issued
// and popped as the router side consumes them; a second instance checks ERR_INJ_EN=0 parity.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       err_inj;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       busy;

    logic       tx_ready, pl_ready, pkt_valid, pkt_done, addr_err;
    logic [7:0] data_out;
    logic       tx_ready_n, pl_ready_n, pkt_valid_n, pkt_done_n, addr_err_n;
    logic [7:0] data_out_n;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         lat;
    logic [7:0] exp_q[$];
    logic [7:0] clean_par;
    logic [7:0] payload [64];
    int         hold [66];

    router_pkt_tx #(.GAP_CYCLES(1), .ERR_INJ_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .addr(addr), .len(len),
        .err_inj(err_inj), .tx_ready(tx_ready), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_ready(pl_ready), .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out),
        .pkt_done(pkt_done), .addr_err(addr_err)
    );

    router_pkt_tx #(.GAP_CYCLES(1), .ERR_INJ_EN(1'b0)) dut_noinj (
        .clock(clock), .reset(reset), .start(start), .addr(addr), .len(len),
        .err_inj(err_inj), .tx_ready(tx_ready_n), .pl_data(pl_data), .pl_valid(pl_valid),
        .pl_ready(pl_ready_n), .busy(busy), .pkt_valid(pkt_valid_n), .data_out(data_out_n),
        .pkt_done(pkt_done_n), .addr_err(addr_err_n)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic flagTimeout(input string tag);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic clearHold();
        for (int k = 0; k < 66; k++) hold[k] = 0;
    endtask

    // Issue one packet request and feed its payload; returns at the negedge showing the header.
    task automatic applyStimulus(input logic [1:0] a, input logic [5:0] l, input logic e,
                                 input bit gaps, output int latency);
        int         guard;
        int         i;
        int         t0;
        logic [7:0] p;
        logic [7:0] h;
        guard = 0;
        while (!tx_ready && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (!tx_ready) flagTimeout("tx_ready_wait");
        h = {l, a};
        p = h;
        exp_q.push_back(h);
        for (int k = 0; k < int'(l); k++) begin
            payload[k] = 8'($urandom);
            p ^= payload[k];
            exp_q.push_back(payload[k]);
        end
        clean_par = p;
        exp_q.push_back(e ? ~p : p);
        start   = 1'b1;
        addr    = a;
        len     = l;
        err_inj = e;
        t0      = cyc;
        @(negedge clock);
        start   = 1'b0;
        err_inj = 1'b0;
        i       = 0;
        guard   = 0;
        while (i < int'(l) && guard < 1000) begin
            if (pl_ready && (!gaps || $urandom_range(0, 2) != 0)) begin
                pl_valid = 1'b1;
                pl_data  = payload[i];
                i++;
            end else begin
                pl_valid = 1'b0;
            end
            @(negedge clock);
            guard++;
        end
        pl_valid = 1'b0;
        if (i < int'(l)) flagTimeout("payload_load");
        latency = cyc - t0;
    endtask

    // Router side: consume up to stop_after words, holding busy for hold[w] cycles on word w.
    task automatic receivePacket(input int l, input int stop_after, input bit poke_start);
        logic [7:0] expv;
        int         nw;
        nw = (stop_after < l + 2) ? stop_after : l + 2;
        for (int w = 0; w < nw; w++) begin
            if (exp_q.size() == 0) begin
                flagTimeout("scoreboard_empty");
                break;
            end
            expv = exp_q.pop_front();
            for (int h = 0; h <= hold[w]; h++) begin
                busy = (h < hold[w]);
                if (poke_start && w == 2 && h == 0) begin
                    start = 1'b1;
                    addr  = 2'd0;
                    len   = 6'd3;
                end else begin
                    start = 1'b0;
                end
                checkOutput($sformatf("word%0d_data", w), data_out, expv);
                checkOutput($sformatf("word%0d_valid", w), {7'd0, pkt_valid}, {7'd0, (w <= l)});
                if (w == l + 1) checkOutput("noinj_parity", data_out_n, clean_par);
                @(negedge clock);
            end
        end
        busy  = 1'b0;
        start = 1'b0;
    endtask

    task automatic checkGap();
        checkOutput("gap_pkt_done", {7'd0, pkt_done}, 8'd1);
        checkOutput("gap_pkt_valid", {7'd0, pkt_valid}, 8'd0);
        checkOutput("gap_data_out", data_out, 8'h00);
        checkOutput("gap_tx_ready", {7'd0, tx_ready}, 8'd0);
        @(negedge clock);
        checkOutput("idle_pkt_done", {7'd0, pkt_done}, 8'd0);
        checkOutput("idle_tx_ready", {7'd0, tx_ready}, 8'd1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        addr     = 2'd0;
        len      = 6'd0;
        err_inj  = 1'b0;
        pl_data  = 8'h00;
        pl_valid = 1'b0;
        busy     = 1'b0;
        clearHold();
        repeat (2) @(negedge clock);
        checkOutput("rst_pkt_valid", {7'd0, pkt_valid}, 8'd0);
        checkOutput("rst_data_out", data_out, 8'h00);
        checkOutput("rst_pl_ready", {7'd0, pl_ready}, 8'd0);
        checkOutput("rst_pkt_done", {7'd0, pkt_done}, 8'd0);
        checkOutput("rst_addr_err", {7'd0, addr_err}, 8'd0);
        checkOutput("rst_tx_ready", {7'd0, tx_ready}, 8'd1);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] addr=2 len=8 back-to-back");
        applyStimulus(2'd2, 6'd8, 1'b0, 1'b0, lat);
        checkOutput("latency_len8", 8'(lat), 8'd9);
        checkOutput("header_len8", data_out, 8'h22);
        receivePacket(8, 99, 1'b0);
        checkGap();

        $display("[TB] busy holds, pl_valid gaps, start poked mid-payload");
        clearHold();
        hold[0] = 2;
        hold[4] = 1;
        applyStimulus(2'd2, 6'd8, 1'b0, 1'b1, lat);
        receivePacket(8, 99, 1'b1);
        checkGap();
        clearHold();

        $display("[TB] len=0 and len=63 boundaries");
        applyStimulus(2'd1, 6'd0, 1'b0, 1'b0, lat);
        checkOutput("latency_len0", 8'(lat), 8'd1);
        checkOutput("header_len0", data_out, 8'h01);
        receivePacket(0, 99, 1'b0);
        checkGap();
        applyStimulus(2'd2, 6'd63, 1'b0, 1'b0, lat);
        checkOutput("latency_len63", 8'(lat), 8'd64);
        checkOutput("header_len63", data_out, 8'hFE);
        receivePacket(63, 99, 1'b0);
        checkGap();

        $display("[TB] parity error injection");
        applyStimulus(2'd0, 6'd4, 1'b1, 1'b1, lat);
        receivePacket(4, 99, 1'b0);
        checkGap();

        $display("[TB] illegal address");
        start = 1'b1;
        addr  = 2'd3;
        len   = 6'd5;
        @(negedge clock);
        start = 1'b0;
        checkOutput("addr_err_pulse", {7'd0, addr_err}, 8'd1);
        checkOutput("addr_err_pkt_valid", {7'd0, pkt_valid}, 8'd0);
        checkOutput("addr_err_tx_ready", {7'd0, tx_ready}, 8'd1);
        checkOutput("addr_err_pl_ready", {7'd0, pl_ready}, 8'd0);
        @(negedge clock);
        checkOutput("addr_err_clear", {7'd0, addr_err}, 8'd0);
        checkOutput("addr_err_still_idle", {7'd0, tx_ready}, 8'd1);

        $display("[TB] reset mid-payload");
        applyStimulus(2'd1, 6'd10, 1'b0, 1'b0, lat);
        receivePacket(10, 4, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        checkOutput("midrst_pkt_valid", {7'd0, pkt_valid}, 8'd0);
        checkOutput("midrst_data_out", data_out, 8'h00);
        checkOutput("midrst_tx_ready", {7'd0, tx_ready}, 8'd1);
        checkOutput("midrst_pl_ready", {7'd0, pl_ready}, 8'd0);
        applyStimulus(2'd0, 6'd5, 1'b0, 1'b1, lat);
        receivePacket(5, 99, 1'b0);
        checkGap();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
